// File: rtl/draw_pkg.sv
// Shared encodings for the rectangle draw engine: command modes and FSM states.
package draw_pkg;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_MOVE    = 2'b10;
    localparam logic [1:0] MODE_CLEAR   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        DRAW,
        CLEAR,
        FIN
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major dx/dy scan counter with loadable column/row limits.
// Reports the border flags needed for outline drawing and the end of the scan.
module raster_counter #(
    parameter int CX_W = 9,
    parameter int CY_W = 9
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [CX_W-1:0] col_max_i,
    input  logic [CY_W-1:0] row_max_i,
    output logic [CX_W-1:0] dx_o,
    output logic [CY_W-1:0] dy_o,
    output logic            first_col_o,
    output logic            first_row_o,
    output logic            last_col_o,
    output logic            last_row_o,
    output logic            last_pix_o
);

    logic [CX_W-1:0] dx_q, dx_d, col_max_q, col_max_d;
    logic [CY_W-1:0] dy_q, dy_d, row_max_q, row_max_d;
    logic            last_col, last_row;

    assign last_col = (dx_q == col_max_q);
    assign last_row = (dy_q == row_max_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dx_q      <= '0;
            dy_q      <= '0;
            col_max_q <= '0;
            row_max_q <= '0;
        end else begin
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            col_max_q <= col_max_d;
            row_max_q <= row_max_d;
        end
    end

    // Load wins over advance so a new phase can start on the last pixel of the old one.
    always_comb begin
        dx_d      = dx_q;
        dy_d      = dy_q;
        col_max_d = col_max_q;
        row_max_d = row_max_q;
        if (load_i) begin
            dx_d      = '0;
            dy_d      = '0;
            col_max_d = col_max_i;
            row_max_d = row_max_i;
        end else if (en_i) begin
            if (last_col) begin
                dx_d = '0;
                dy_d = last_row ? '0 : dy_q + CY_W'(1);
            end else begin
                dx_d = dx_q + CX_W'(1);
            end
        end
    end

    assign dx_o        = dx_q;
    assign dy_o        = dy_q;
    assign first_col_o = (dx_q == '0);
    assign first_row_o = (dy_q == '0);
    assign last_col_o  = last_col;
    assign last_row_o  = last_row;
    assign last_pix_o  = last_col && last_row;

endmodule

// File: rtl/rect_draw_engine.sv
// Command-driven rectangle engine (fill/outline/move/clear) emitting one pixel per clock.
// Define CLIP_EN to suppress plots that fall outside SCREEN_W x SCREEN_H.
module rect_draw_engine
    import draw_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int COLOUR_W = 3,
    parameter int DIM_W    = 6
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      old_x,
    input  logic [Y_W-1:0]      old_y,
    input  logic [DIM_W-1:0]    w,
    input  logic [DIM_W-1:0]    h,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour
);

    state_t state_q, state_d;

    logic [1:0]          mode_q;
    logic [X_W-1:0]      x0_q, old_x_q;
    logic [Y_W-1:0]      y0_q, old_y_q;
    logic [DIM_W-1:0]    w_q, h_q;
    logic [COLOUR_W-1:0] fg_q, bg_q;

    logic                busy_q, done_q, plot_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;

    logic           accept;
    logic           cnt_load, cnt_en;
    logic [X_W-1:0] col_max, dx;
    logic [Y_W-1:0] row_max, dy;
    logic           first_col, first_row, last_col, last_row, last_pix;

    logic                pix_active, mode_ok, in_range;
    logic [X_W-1:0]      base_x, pix_x;
    logic [Y_W-1:0]      base_y, pix_y;
    logic [COLOUR_W-1:0] pix_colour;

    assign accept = (state_q == IDLE) && start;

    raster_counter #(
        .CX_W(X_W),
        .CY_W(Y_W)
    ) u_raster (
        .clk_i      (CLOCK_50),
        .rst_ni     (resetn),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .col_max_i  (col_max),
        .row_max_i  (row_max),
        .dx_o       (dx),
        .dy_o       (dy),
        .first_col_o(first_col),
        .first_row_o(first_row),
        .last_col_o (last_col),
        .last_row_o (last_row),
        .last_pix_o (last_pix)
    );

    // In IDLE the limits come straight from the command inputs so the scan starts next cycle.
    always_comb begin
        col_max = X_W'(w_q) - X_W'(1);
        row_max = Y_W'(h_q) - Y_W'(1);
        if (state_q == IDLE) begin
            if (mode == MODE_CLEAR) begin
                col_max = X_W'(SCREEN_W - 1);
                row_max = Y_W'(SCREEN_H - 1);
            end else begin
                col_max = X_W'(w) - X_W'(1);
                row_max = Y_W'(h) - Y_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    if (mode == MODE_CLEAR) begin
                        state_d = CLEAR;
                    end else if ((w == '0) || (h == '0)) begin
                        state_d = FIN;
                    end else if (mode == MODE_MOVE) begin
                        state_d = ERASE;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            ERASE: begin
                cnt_en = 1'b1;
                if (last_pix) begin
                    cnt_load = 1'b1;
                    state_d  = DRAW;
                end
            end
            DRAW, CLEAR: begin
                cnt_en = 1'b1;
                if (last_pix) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pix_active = 1'b0;
        base_x     = '0;
        base_y     = '0;
        pix_colour = bg_q;
        mode_ok    = 1'b1;
        case (state_q)
            ERASE: begin
                pix_active = 1'b1;
                base_x     = old_x_q;
                base_y     = old_y_q;
            end
            DRAW: begin
                pix_active = 1'b1;
                base_x     = x0_q;
                base_y     = y0_q;
                pix_colour = fg_q;
                if (mode_q == MODE_OUTLINE) begin
                    mode_ok = first_col || last_col || first_row || last_row;
                end
            end
            CLEAR: begin
                pix_active = 1'b1;
            end
            default: begin
                pix_active = 1'b0;
            end
        endcase
    end

`ifdef CLIP_EN
    // One extra bit keeps positions past the coordinate range from aliasing back on screen.
    localparam logic [X_W:0] SCREEN_W_L = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCREEN_H_L = (Y_W+1)'(SCREEN_H);
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    assign sum_x    = {1'b0, base_x} + {1'b0, dx};
    assign sum_y    = {1'b0, base_y} + {1'b0, dy};
    assign in_range = (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);
    assign pix_x    = sum_x[X_W-1:0];
    assign pix_y    = sum_y[Y_W-1:0];
`else
    assign in_range = 1'b1;
    assign pix_x    = base_x + dx;
    assign pix_y    = base_y + dy;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == FIN);
            plot_q <= pix_active && mode_ok && in_range;
            if (pix_active) begin
                x_q      <= pix_x;
                y_q      <= pix_y;
                colour_q <= pix_colour;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            mode_q  <= MODE_FILL;
            x0_q    <= '0;
            y0_q    <= '0;
            old_x_q <= '0;
            old_y_q <= '0;
            w_q     <= '0;
            h_q     <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
        end else if (accept) begin
            mode_q  <= mode;
            x0_q    <= x0;
            y0_q    <= y0;
            old_x_q <= old_x;
            old_y_q <= old_y;
            w_q     <= w;
            h_q     <= h;
            fg_q    <= fg_colour;
            bg_q    <= bg_colour;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule
